perceptron_trainer: RTL and testbench
=====================================

Name: perceptron_trainer

Overview:
- Sequences online training of the two-input Q4.12 perceptron neuron.
- Accepts labelled samples over a valid/ready stream and drives them onto the neuron's IN1/IN2.
- Reads the threshold result and applies the perceptron rule w += LR*(target-result)*x through the neuron's weight load ports.
- Counts errors per epoch; stops on a zero-error epoch (converged) or after MAX_EPOCHS.

Parameters:
- LR, 16'h0400, learning rate, signed Q4.12 (0x0400 = 0.25).
- MAX_EPOCHS, 16, epoch limit before giving up; must be 1..255.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle pulse, begins training
- num_samples  in  8  samples per epoch, latched on accepted start
- s_valid  in  1  sample valid
- s_ready  out  1  trainer accepts a sample
- s_x1  in  16  sample input 1, Q4.12
- s_x2  in  16  sample input 2, Q4.12
- s_target  in  1  desired class (0/1)
- p_in1  out  16  to neuron IN1
- p_in2  out  16  to neuron IN2
- p_result  in  1  neuron threshold output
- p_weight1  in  16  neuron current weight1
- p_weight2  in  16  neuron current weight2
- p_weight1_new  out  16  to neuron weight1_new
- p_weight2_new  out  16  to neuron weight2_new
- p_weight1_ld  out  1  to neuron weight1_ld
- p_weight2_ld  out  1  to neuron weight2_ld
- busy  out  1  training in progress
- done  out  1  training finished, held until next accepted start
- converged  out  1  valid when done; 1 = last epoch had zero errors
- epoch_count  out  8  completed epochs
- error_count  out  8  errors in the current/last epoch

Behaviour:
- Reset (rst=1 at clk edge):
  - State goes to IDLE.
  - All outputs go to 0: s_ready, p_in*, p_weight*_new, p_weight*_ld, busy, done, converged, epoch_count, error_count.
  - Reset mid-operation abandons the sample with no ld pulse. Neuron weights are not touched; they have their own reset.
- FSM states: IDLE, FETCH, EVAL, UPDATE, COUNT, DONE.
- IDLE/DONE:
  - start=1 with num_samples!=0 → FETCH.
  - On that transition: latch num_samples; clear epoch_count, error_count, sample counter, done, converged; set busy=1.
  - start with num_samples==0 is ignored.
  - start is ignored in every other state.
- FETCH:
  - s_ready=1.
  - On s_valid&&s_ready: register x1→p_in1, x2→p_in2 and the target; go to EVAL.
  - s_valid low holds FETCH indefinitely.
  - p_in1/p_in2 hold their last value outside FETCH.
- EVAL (one cycle, p_in stable):
  - err = target - p_result, in {-1, 0, +1}.
  - err!=0 → UPDATE; err==0 → COUNT.
- UPDATE (one cycle):
  - p_weight1_ld = p_weight2_ld = 1. Ld is never asserted in any other state.
  - d_i = (sext32(LR) * sext32(x_i)) >>> 12, truncated to 16 bits.
  - new_i = p_weight_i + d_i when err=+1; p_weight_i - d_i when err=-1. 16-bit two's complement, wraps, no saturation.
  - error_count increments, saturating at 255.
  - Next state COUNT.
- COUNT:
  - When the sample counter is below num_samples-1: increment it and go to FETCH.
  - Otherwise (epoch end): epoch_count++.
  - If error_count==0 → DONE with converged=1.
  - Else if epoch_count+1==MAX_EPOCHS → DONE with converged=0.
  - Else clear sample counter and error_count, go to FETCH.
- DONE: busy=0, done=1; error_count and epoch_count hold.
- Latency:
  - Handshake to ld pulse: 2 cycles.
  - Handshake to next s_ready: 3 cycles without update, 4 cycles with update.

Test Plan:
- Update on error: neuron weights 0, LR=0x0400, num_samples=2, sample (0x1000, 0x1000, target 0) → result 1, err=-1. UPDATE drives new=0xFC00/0xFC00 with both ld=1 for exactly 1 cycle, 2 cycles after handshake; error_count=1.
- No update on correct: weights 0, sample (0x1000, 0x0000, target 1) → no ld pulse; s_ready returns 3 cycles after handshake.
- Convergence: num_samples=1, weights 0, sample (0x1000, 0x1000, target 1) → done=1, converged=1, epoch_count=1, error_count=0, busy=0.
- Non-convergence: MAX_EPOCHS=3, num_samples=2, stream (0x1000, 0x1000, 1) then (0x1000, 0x1000, 0) repeated → done=1, converged=0, epoch_count=3.
- Back-pressure/ignore:
  - s_valid low for 10 cycles in FETCH → state holds, s_ready stays 1, no ld.
  - start pulsed while busy → no effect.
  - start with num_samples=0 → remains IDLE.
- Reset mid-op: rst=1 in the UPDATE cycle → next cycle all outputs 0, ld low, state IDLE; a subsequent start runs normally.

Source files
------------

// File: rtl/perceptron_trainer_if.sv
// Sample stream and neuron-side bus of the perceptron trainer.
// slave = trainer side, master = sample source / neuron side.
interface perceptron_trainer_if;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_x1;
  logic [15:0] s_x2;
  logic        s_target;
  logic [15:0] p_in1;
  logic [15:0] p_in2;
  logic        p_result;
  logic [15:0] p_weight1;
  logic [15:0] p_weight2;
  logic [15:0] p_weight1_new;
  logic [15:0] p_weight2_new;
  logic        p_weight1_ld;
  logic        p_weight2_ld;

  modport slave (
    input  s_valid, s_x1, s_x2, s_target, p_result, p_weight1, p_weight2,
    output s_ready, p_in1, p_in2, p_weight1_new, p_weight2_new,
           p_weight1_ld, p_weight2_ld
  );

  modport master (
    output s_valid, s_x1, s_x2, s_target, p_result, p_weight1, p_weight2,
    input  s_ready, p_in1, p_in2, p_weight1_new, p_weight2_new,
           p_weight1_ld, p_weight2_ld
  );
endinterface

// File: rtl/perceptron_trainer.sv
// Online perceptron-rule trainer for a two-input Q4.12 neuron: streams samples
// in, compares the neuron's decision to the label and loads corrected weights.
module perceptron_trainer #(
  parameter logic signed [15:0] LR         = 16'sh0400,
  parameter int                 MAX_EPOCHS = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [7:0]                 num_samples,
  perceptron_trainer_if.slave        bus,
  output logic                       busy,
  output logic                       done,
  output logic                       converged,
  output logic [7:0]                 epoch_count,
  output logic [7:0]                 error_count
);

  typedef enum logic [2:0] {IDLE, FETCH, EVAL, UPDATE, COUNT, DONE} state_t;

  localparam logic signed [31:0] LR_EXT     = 32'(LR);
  localparam logic [8:0]         MAX_EP_LIM = 9'(MAX_EPOCHS);

  state_t      state_reg, state_next;
  logic [7:0]  num_reg, num_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic [7:0]  epoch_reg, epoch_next;
  logic [7:0]  errc_reg, errc_next;
  logic [15:0] in1_reg, in1_next;
  logic [15:0] in2_reg, in2_next;
  logic        target_reg, target_next;
  logic        busy_reg, busy_next;
  logic        done_reg, done_next;
  logic        conv_reg, conv_next;

  logic        upd;
  logic [15:0] lane_x   [2];
  logic [15:0] lane_w   [2];
  logic [15:0] lane_new [2];

  assign lane_x[0] = in1_reg;
  assign lane_x[1] = in2_reg;
  assign lane_w[0] = bus.p_weight1;
  assign lane_w[1] = bus.p_weight2;

  // In UPDATE the error is nonzero, so its sign is simply the stored target.
  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    logic signed [31:0] x_ext;
    logic [15:0]        delta;
    assign x_ext         = {{16{lane_x[gi][15]}}, lane_x[gi]};
    assign delta         = 16'((LR_EXT * x_ext) >>> 12);
    assign lane_new[gi]  = target_reg ? (lane_w[gi] + delta) : (lane_w[gi] - delta);
  end

  assign upd               = (state_reg == UPDATE);
  assign bus.s_ready       = (state_reg == FETCH);
  assign bus.p_in1         = in1_reg;
  assign bus.p_in2         = in2_reg;
  assign bus.p_weight1_new = upd ? lane_new[0] : 16'd0;
  assign bus.p_weight2_new = upd ? lane_new[1] : 16'd0;
  // A reset landing on the UPDATE cycle must not commit the weight load.
  assign bus.p_weight1_ld  = upd && !rst;
  assign bus.p_weight2_ld  = upd && !rst;
  assign busy              = busy_reg;
  assign done              = done_reg;
  assign converged         = conv_reg;
  assign epoch_count       = epoch_reg;
  assign error_count       = errc_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      num_reg    <= '0;
      cnt_reg    <= '0;
      epoch_reg  <= '0;
      errc_reg   <= '0;
      in1_reg    <= '0;
      in2_reg    <= '0;
      target_reg <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      conv_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      num_reg    <= num_next;
      cnt_reg    <= cnt_next;
      epoch_reg  <= epoch_next;
      errc_reg   <= errc_next;
      in1_reg    <= in1_next;
      in2_reg    <= in2_next;
      target_reg <= target_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
      conv_reg   <= conv_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    num_next    = num_reg;
    cnt_next    = cnt_reg;
    epoch_next  = epoch_reg;
    errc_next   = errc_reg;
    in1_next    = in1_reg;
    in2_next    = in2_reg;
    target_next = target_reg;
    busy_next   = busy_reg;
    done_next   = done_reg;
    conv_next   = conv_reg;

    case (state_reg)
      IDLE, DONE: begin
        if (start && (num_samples != 8'd0)) begin
          state_next = FETCH;
          num_next   = num_samples;
          cnt_next   = '0;
          epoch_next = '0;
          errc_next  = '0;
          done_next  = 1'b0;
          conv_next  = 1'b0;
          busy_next  = 1'b1;
        end
      end
      FETCH: begin
        if (bus.s_valid) begin
          in1_next    = bus.s_x1;
          in2_next    = bus.s_x2;
          target_next = bus.s_target;
          state_next  = EVAL;
        end
      end
      EVAL: begin
        state_next = (target_reg != bus.p_result) ? UPDATE : COUNT;
      end
      UPDATE: begin
        if (errc_reg != 8'hFF) begin
          errc_next = errc_reg + 8'd1;
        end
        state_next = COUNT;
      end
      COUNT: begin
        if (cnt_reg < (num_reg - 8'd1)) begin
          cnt_next   = cnt_reg + 8'd1;
          state_next = FETCH;
        end else begin
          epoch_next = epoch_reg + 8'd1;
          if (errc_reg == 8'd0) begin
            state_next = DONE;
            conv_next  = 1'b1;
            done_next  = 1'b1;
            busy_next  = 1'b0;
          end else if (({1'b0, epoch_reg} + 9'd1) == MAX_EP_LIM) begin
            state_next = DONE;
            conv_next  = 1'b0;
            done_next  = 1'b1;
            busy_next  = 1'b0;
          end else begin
            cnt_next   = '0;
            errc_next  = '0;
            state_next = FETCH;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_perceptron_trainer.sv
// Scoreboarded bench for perceptron_trainer driving a behavioural Q4.12 neuron
// whose decision is (w1*in1 + w2*in2 >= 0).
module tb_perceptron_trainer;

  logic       clk = 1'b0;
  logic       rst;
  logic       nrst;
  logic       start;
  logic [7:0] num_samples;
  logic       busy, done, converged;
  logic [7:0] epoch_count, error_count;

  perceptron_trainer_if bus();

  perceptron_trainer #(.LR(16'sh0400), .MAX_EPOCHS(3)) dut (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples), .bus(bus),
    .busy(busy), .done(done), .converged(converged),
    .epoch_count(epoch_count), .error_count(error_count)
  );

  always #5 clk = ~clk;

  // Behavioural neuron
  logic signed [15:0] w1, w2;
  logic signed [31:0] acc;
  always_ff @(posedge clk) begin
    if (nrst) begin
      w1 <= '0;
      w2 <= '0;
    end else begin
      if (bus.p_weight1_ld) w1 <= bus.p_weight1_new;
      if (bus.p_weight2_ld) w2 <= bus.p_weight2_new;
    end
  end
  assign acc           = w1 * $signed(bus.p_in1) + w2 * $signed(bus.p_in2);
  assign bus.p_result  = (acc >= 32'sd0);
  assign bus.p_weight1 = w1;
  assign bus.p_weight2 = w2;

  int checks = 0;
  int fails  = 0;
  logic [31:0] ld_q   [$];
  logic [16:0] done_q [$];

  // Hand-computed non-convergence stream: x=(1.0,1.0), targets alternate 1/0.
  bit          nc_t    [6] = '{1, 0, 1, 0, 1, 0};
  bit          nc_ld   [6] = '{0, 1, 1, 1, 1, 1};
  logic [31:0] nc_wexp [6] = '{32'h0, 32'hFC00FC00, 32'h0, 32'hFC00FC00, 32'h0, 32'hFC00FC00};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a load or finishes.
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    logic [31:0] e;
    logic [16:0] d;
    if (bus.p_weight1_ld || bus.p_weight2_ld) begin
      if (ld_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_ld: got ld with new=%h/%h, required no ld",
                 bus.p_weight1_new, bus.p_weight2_new);
      end else begin
        e = ld_q.pop_front();
        chk("ld_both", {30'b0, bus.p_weight1_ld, bus.p_weight2_ld}, 32'd3);
        chk("ld_weights", {bus.p_weight1_new, bus.p_weight2_new}, e);
      end
    end
    if (done && !done_prev) begin
      if (done_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_done: got done=1, required 0");
      end else begin
        d = done_q.pop_front();
        chk("done_result", {15'b0, converged, epoch_count, error_count}, {15'b0, d});
        chk("done_busy", {31'b0, busy}, 32'd0);
      end
    end
    done_prev = done;
  end

  task automatic check_idle(input string tag);
    chk({tag, "_ctrl"}, {26'b0, bus.s_ready, busy, done, converged,
                         bus.p_weight1_ld, bus.p_weight2_ld}, 32'd0);
    chk({tag, "_counts"}, {16'b0, epoch_count, error_count}, 32'd0);
    chk({tag, "_pin"}, {bus.p_in1, bus.p_in2}, 32'd0);
    chk({tag, "_wnew"}, {bus.p_weight1_new, bus.p_weight2_new}, 32'd0);
  endtask

  task automatic start_run(input logic [7:0] n);
    num_samples = n;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Issue one sample; report cycle of first ld, ld width, cycle s_ready returns,
  // and error_count on the cycle after the ld (cycle 1 = first after handshake).
  task automatic send(input logic [15:0] x1, input logic [15:0] x2, input logic t,
                      output int ld_at, output int ld_n, output int rdy_at, output int ec_post);
    int w = 0;
    ld_at = -1; ld_n = 0; rdy_at = -1; ec_post = -1;
    while (!bus.s_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    chk("ready_wait", {31'b0, bus.s_ready}, 32'd1);
    bus.s_x1 = x1; bus.s_x2 = x2; bus.s_target = t; bus.s_valid = 1'b1;
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (bus.p_weight1_ld) begin
        if (ld_at < 0) ld_at = c;
        ld_n++;
      end
      if (ld_at > 0 && c == ld_at + 1) ec_post = int'(error_count);
      if (bus.s_ready) begin
        rdy_at = c;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_done();
    int w = 0;
    while (!done && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    chk("done_wait", {31'b0, done}, 32'd1);
  endtask

  initial begin
    int la, ln, ra, ec;
    bit bp_ok;
    rst = 1'b1; nrst = 1'b1; start = 1'b0; num_samples = '0;
    bus.s_valid = 1'b0; bus.s_x1 = '0; bus.s_x2 = '0; bus.s_target = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    rst = 1'b0; nrst = 1'b0;

    // start with zero samples is ignored
    start_run(8'd0);
    @(posedge clk); #1;
    chk("zero_start_busy", {30'b0, busy, bus.s_ready}, 32'd0);

    // Run 1: num_samples=2, weights 0
    start_run(8'd2);
    chk("run1_start", {30'b0, busy, bus.s_ready}, 32'd3);
    send(16'h1000, 16'h0000, 1'b1, la, ln, ra, ec);
    chk("correct_no_ld", ln, 0);
    chk("correct_rdy_lat", ra, 3);

    ld_q.push_back(32'hFC00FC00);
    send(16'h1000, 16'h1000, 1'b0, la, ln, ra, ec);
    chk("err_ld_lat", la, 2);
    chk("err_ld_width", ln, 1);
    chk("err_rdy_lat", ra, 4);
    chk("err_count_post", ec, 1);
    chk("epoch1_end", {16'b0, epoch_count, error_count}, {16'b0, 8'd1, 8'd0});

    // Back-pressure with a start pulse while busy
    bp_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        start = 1'b1;
        num_samples = 8'd5;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (!bus.s_ready || bus.p_weight1_ld || bus.p_weight2_ld) bp_ok = 1'b0;
    end
    start = 1'b0;
    chk("backpressure_hold", {31'b0, bp_ok}, 32'd1);
    chk("busy_start_ignored", {23'b0, busy, epoch_count}, {23'b0, 1'b1, 8'd1});

    ld_q.push_back(32'h00000000);
    send(16'h1000, 16'h1000, 1'b1, la, ln, ra, ec);
    chk("pos_err_ld_lat", la, 2);

    // Reset on the UPDATE cycle: no load, everything back to zero
    bus.s_x1 = 16'h1000; bus.s_x2 = 16'h1000; bus.s_target = 1'b0; bus.s_valid = 1'b1;
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst_no_ld", {30'b0, bus.p_weight1_ld, bus.p_weight2_ld}, 32'd0);
    @(posedge clk); #1;
    check_idle("midrst");
    rst = 1'b0;

    // Run 2: convergence in one epoch
    done_q.push_back({1'b1, 8'd1, 8'd0});
    start_run(8'd1);
    send(16'h1000, 16'h1000, 1'b1, la, ln, ra, ec);
    chk("conv_no_ld", ln, 0);
    wait_done();
    chk("conv_final", {15'b0, busy, converged, epoch_count, error_count},
        {15'b0, 1'b0, 1'b1, 8'd1, 8'd0});

    // Run 3: non-convergence, restarted from DONE
    done_q.push_back({1'b0, 8'd3, 8'd2});
    start_run(8'd2);
    chk("restart_clears_done", {30'b0, done, busy}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      if (nc_ld[i]) ld_q.push_back(nc_wexp[i]);
      send(16'h1000, 16'h1000, nc_t[i], la, ln, ra, ec);
      chk($sformatf("nc_ld_count_%0d", i), ln, nc_ld[i] ? 1 : 0);
    end
    wait_done();
    chk("nonconv_final", {23'b0, converged, epoch_count}, {23'b0, 1'b0, 8'd3});

    repeat (2) @(posedge clk);
    #1;
    chk("ld_queue_drained", ld_q.size(), 0);
    chk("done_queue_drained", done_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
